// File: rtl/palette_pkg.sv
// -----------------------------------------------------------------------------
// palette_pkg
// Shared types and default constants for the multi-bank palette LUT.
//   rgb_t        : packed {r,g,b} colour triple at the default channel width
//   clr_state_t  : bulk-clear engine states (CLR_IDLE, CLR_CLEAR)
//   DEF_*        : default geometry used as parameter defaults by the top
// -----------------------------------------------------------------------------
package palette_pkg;

  localparam int DEF_INDEX_W      = 4;
  localparam int DEF_COLOR_W      = 4;
  localparam int DEF_NUM_PALETTES = 4;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/palette_fade_scaler.sv
// -----------------------------------------------------------------------------
// palette_fade_scaler
// One colour channel brightness reduction: c_out = floor(c_in*(16-fade_level)/16).
// Purely combinational; the caller registers the result.
// Only present when MULTI_PALETTE_FADE_EN is defined (the top uses it only then).
// Ports:
//   c_in        in  COLOR_W  channel value before fade
//   fade_level  in  4        reduction step, 0 = unchanged, 15 = darkest
//   c_out       out COLOR_W  faded channel value
// -----------------------------------------------------------------------------
`ifdef MULTI_PALETTE_FADE_EN
module palette_fade_scaler #(
  parameter int COLOR_W = 4
) (
  input  logic [COLOR_W-1:0] c_in,
  input  logic [3:0]         fade_level,
  output logic [COLOR_W-1:0] c_out
);

  logic [4:0]         scale_s;
  logic [COLOR_W+4:0] prod_s;

  // Multiply by (16 - fade) in a COLOR_W+5 bit product, then drop 4 LSBs.
  always_comb begin
    scale_s = 5'd16 - {1'b0, fade_level};
    prod_s  = {5'b00000, c_in} * {{COLOR_W{1'b0}}, scale_s};
    c_out   = prod_s[COLOR_W+3:4];
  end

endmodule
`endif

// File: rtl/multi_palette_lut.sv
// -----------------------------------------------------------------------------
// multi_palette_lut
// Runtime-writable multi-bank colour palette. (bank, index) -> RGB through a
// two-stage read pipeline, with a transparency flag and a sequenced bulk clear.
// Optional feature macro: MULTI_PALETTE_FADE_EN (adds fade_level and per-channel
// brightness reduction in the output stage).
// Ports:
//   Clk, Reset                      clock, asynchronous active-high reset
//   rd_valid/rd_pal/rd_index        lookup request
//   rd_out_valid/red/green/blue     lookup result, 2 cycles after request
//   transparent                     result index matched TRANSP_INDEX
//   wr_en/wr_pal/wr_index/wr_rgb    single entry write ({r,g,b})
//   clear_req                       start bulk clear of every bank
//   busy                            bulk clear in progress
//   fade_level                      brightness reduction (fade build only)
// -----------------------------------------------------------------------------
module multi_palette_lut
  import palette_pkg::*;
#(
  parameter int INDEX_W      = DEF_INDEX_W,
  parameter int NUM_PALETTES = DEF_NUM_PALETTES,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int TRANSP_INDEX = 0,
  localparam int PAL_W       = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   rd_valid,
  input  logic [PAL_W-1:0]       rd_pal,
  input  logic [INDEX_W-1:0]     rd_index,
  output logic                   rd_out_valid,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   transparent,
  input  logic                   wr_en,
  input  logic [PAL_W-1:0]       wr_pal,
  input  logic [INDEX_W-1:0]     wr_index,
  input  logic [3*COLOR_W-1:0]   wr_rgb,
  input  logic                   clear_req,
`ifdef MULTI_PALETTE_FADE_EN
  input  logic [3:0]             fade_level,
`endif
  output logic                   busy
);

  localparam int ADDR_W  = PAL_W + INDEX_W;
  localparam int ENTRIES = NUM_PALETTES * (2 ** INDEX_W);
  localparam int RGB_W   = 3 * COLOR_W;
  localparam logic [PAL_W:0]     NUM_PAL_L = (PAL_W+1)'(NUM_PALETTES);
  localparam logic [INDEX_W-1:0] TRANSP_L  = INDEX_W'(TRANSP_INDEX);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(ENTRIES - 1);

  logic [RGB_W-1:0]   mem_q [ENTRIES];
  logic [RGB_W-1:0]   mem_d [ENTRIES];
  clr_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic               busy_q, busy_d;

  logic               s1_valid_q, s1_valid_d;
  logic [RGB_W-1:0]   s1_rgb_q, s1_rgb_d;
  logic               s1_transp_q, s1_transp_d;

  logic               out_valid_q, out_valid_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               transp_q, transp_d;

  logic [ADDR_W-1:0]  rd_addr_s, wr_addr_s;
  logic               rd_pal_ok_s, wr_ok_s;
  logic [RGB_W-1:0]   faded_rgb_s;

  assign rd_addr_s   = {rd_pal, rd_index};
  assign wr_addr_s   = {wr_pal, wr_index};
  assign rd_pal_ok_s = ({1'b0, rd_pal} < NUM_PAL_L);
  // Host writes lose to the clear engine for its whole duration.
  assign wr_ok_s     = wr_en && !busy_q && ({1'b0, wr_pal} < NUM_PAL_L);

  // Clear engine next state: one entry per cycle, linear over {bank,index}.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clear_req) begin
          state_d   = CLR_CLEAR;
          clr_cnt_d = {ADDR_W{1'b0}};
        end else begin
          state_d   = CLR_IDLE;
        end
      end
      CLR_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = CLR_IDLE;
          clr_cnt_d = {ADDR_W{1'b0}};
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d   = CLR_IDLE;
        clr_cnt_d = {ADDR_W{1'b0}};
      end
    endcase
    busy_d = (state_d == CLR_CLEAR);
  end

  // Array next state: clear engine slot, otherwise the host write.
  always_comb begin
    mem_d = mem_q;
    if (state_q == CLR_CLEAR) begin
      mem_d[clr_cnt_q] = {RGB_W{1'b0}};
    end else if (wr_ok_s) begin
      mem_d[wr_addr_s] = wr_rgb;
    end else begin
      mem_d = mem_q;
    end
  end

  // Stage 1: capture the stored word (read-first) and the transparency compare.
  always_comb begin
    s1_valid_d = rd_valid;
    if (rd_valid) begin
      s1_rgb_d    = rd_pal_ok_s ? mem_q[rd_addr_s] : {RGB_W{1'b0}};
      s1_transp_d = (rd_index == TRANSP_L);
    end else begin
      s1_rgb_d    = s1_rgb_q;
      s1_transp_d = s1_transp_q;
    end
  end

`ifdef MULTI_PALETTE_FADE_EN
  palette_fade_scaler #(.COLOR_W(COLOR_W)) u_fade_r (
    .c_in(s1_rgb_q[3*COLOR_W-1:2*COLOR_W]), .fade_level(fade_level),
    .c_out(faded_rgb_s[3*COLOR_W-1:2*COLOR_W]));
  palette_fade_scaler #(.COLOR_W(COLOR_W)) u_fade_g (
    .c_in(s1_rgb_q[2*COLOR_W-1:COLOR_W]), .fade_level(fade_level),
    .c_out(faded_rgb_s[2*COLOR_W-1:COLOR_W]));
  palette_fade_scaler #(.COLOR_W(COLOR_W)) u_fade_b (
    .c_in(s1_rgb_q[COLOR_W-1:0]), .fade_level(fade_level),
    .c_out(faded_rgb_s[COLOR_W-1:0]));
`else
  assign faded_rgb_s = s1_rgb_q;
`endif

  // Stage 2: output registers; colour/transparent hold when no result arrives.
  always_comb begin
    out_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      red_d    = faded_rgb_s[3*COLOR_W-1:2*COLOR_W];
      green_d  = faded_rgb_s[2*COLOR_W-1:COLOR_W];
      blue_d   = faded_rgb_s[COLOR_W-1:0];
      transp_d = s1_transp_q;
    end else begin
      red_d    = red_q;
      green_d  = green_q;
      blue_d   = blue_q;
      transp_d = transp_q;
    end
  end

  // Palette storage; reset zeroes every entry of every bank.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= {RGB_W{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Clear engine and read pipeline registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= CLR_IDLE;
      clr_cnt_q   <= {ADDR_W{1'b0}};
      busy_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_rgb_q    <= {RGB_W{1'b0}};
      s1_transp_q <= 1'b0;
      out_valid_q <= 1'b0;
      red_q       <= {COLOR_W{1'b0}};
      green_q     <= {COLOR_W{1'b0}};
      blue_q      <= {COLOR_W{1'b0}};
      transp_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      busy_q      <= busy_d;
      s1_valid_q  <= s1_valid_d;
      s1_rgb_q    <= s1_rgb_d;
      s1_transp_q <= s1_transp_d;
      out_valid_q <= out_valid_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      transp_q    <= transp_d;
    end
  end

  assign rd_out_valid = out_valid_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign transparent  = transp_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_multi_palette_lut.sv
// -----------------------------------------------------------------------------
// tb_multi_palette_lut
// Directed self-checking bench for multi_palette_lut (INDEX_W=4, NUM_PALETTES=4,
// COLOR_W=4, TRANSP_INDEX=0). Fade checks are compiled with MULTI_PALETTE_FADE_EN.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_multi_palette_lut;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_valid = 1'b0;
  logic [1:0]  rd_pal = 2'd0;
  logic [3:0]  rd_index = 4'd0;
  logic        rd_out_valid;
  logic [3:0]  red, green, blue;
  logic        transparent;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_pal = 2'd0;
  logic [3:0]  wr_index = 4'd0;
  logic [11:0] wr_rgb = 12'h000;
  logic        clear_req = 1'b0;
  logic        busy;
`ifdef MULTI_PALETTE_FADE_EN
  logic [3:0]  fade_level = 4'd0;
`endif

  int total = 0;
  int bad   = 0;

  multi_palette_lut #(
    .INDEX_W(4), .NUM_PALETTES(4), .COLOR_W(4), .TRANSP_INDEX(0)
  ) dut (
    .Clk(clk), .Reset(rst),
    .rd_valid(rd_valid), .rd_pal(rd_pal), .rd_index(rd_index),
    .rd_out_valid(rd_out_valid), .red(red), .green(green), .blue(blue),
    .transparent(transparent),
    .wr_en(wr_en), .wr_pal(wr_pal), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .clear_req(clear_req),
`ifdef MULTI_PALETTE_FADE_EN
    .fade_level(fade_level),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] p, input logic [3:0] i, input logic [11:0] d);
    wr_en = 1'b1; wr_pal = p; wr_index = i; wr_rgb = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({rd_out_valid, red, green, blue, transparent, busy} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {rd_out_valid, red, green, blue, transparent, busy});
    end
    rst = 1'b0;
    tick();
    rd_valid = 1'b1; rd_pal = 2'd2; rd_index = 4'd9;
    tick();
    rd_valid = 1'b0;
    tick();
    total++;
    if (rd_out_valid !== 1'b1 || {red, green, blue} !== 12'h000) begin
      bad++;
      $display("FAIL reset_entry got=%b/%h want=1/000", rd_out_valid, {red, green, blue});
    end
  endtask

  task automatic test_write_read();
    do_write(2'd1, 4'd5, 12'hA3F);
    rd_valid = 1'b1; rd_pal = 2'd1; rd_index = 4'd5;
    tick();
    rd_valid = 1'b0;
    total++;
    if (rd_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early got=%b want=0", rd_out_valid);
    end
    tick();
    total++;
    if (rd_out_valid !== 1'b1 || {red, green, blue} !== 12'hA3F || transparent !== 1'b0) begin
      bad++;
      $display("FAIL write_read got=%b/%h/%b want=1/a3f/0", rd_out_valid, {red, green, blue}, transparent);
    end
    tick();
    total++;
    if (rd_out_valid !== 1'b0 || {red, green, blue} !== 12'hA3F) begin
      bad++;
      $display("FAIL hold_outputs got=%b/%h want=0/a3f", rd_out_valid, {red, green, blue});
    end
  endtask

  task automatic test_read_first();
    wr_en = 1'b1; wr_pal = 2'd0; wr_index = 4'd7; wr_rgb = 12'h123;
    rd_valid = 1'b1; rd_pal = 2'd0; rd_index = 4'd7;
    tick();
    wr_en = 1'b0; rd_valid = 1'b0;
    tick();
    total++;
    if (rd_out_valid !== 1'b1 || {red, green, blue} !== 12'h000) begin
      bad++;
      $display("FAIL read_first_old got=%b/%h want=1/000", rd_out_valid, {red, green, blue});
    end
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    tick();
    total++;
    if (rd_out_valid !== 1'b1 || {red, green, blue} !== 12'h123) begin
      bad++;
      $display("FAIL read_first_new got=%b/%h want=1/123", rd_out_valid, {red, green, blue});
    end
  endtask

  task automatic test_transparent_stream();
    logic [3:0]  k;
    logic [11:0] exp_rgb;
    rd_valid = 1'b1; rd_pal = 2'd2; rd_index = 4'd0;
    tick();
    rd_valid = 1'b0;
    tick();
    total++;
    if (rd_out_valid !== 1'b1 || transparent !== 1'b1) begin
      bad++;
      $display("FAIL transparent_idx0 got=%b/%b want=1/1", rd_out_valid, transparent);
    end
    // bank 3 entry i = {i, 15-i, i^5}
    for (int i = 0; i < 16; i++) begin
      k = i[3:0];
      do_write(2'd3, k, {k, 4'hF - k, k ^ 4'h5});
    end
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        rd_valid = 1'b1; rd_pal = 2'd3; rd_index = i[3:0];
      end else begin
        rd_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 16) begin
        k = 4'(i - 1);
        exp_rgb = {k, 4'hF - k, k ^ 4'h5};
        total++;
        if (rd_out_valid !== 1'b1 || {red, green, blue} !== exp_rgb ||
            transparent !== (k == 4'd0)) begin
          bad++;
          $display("FAIL stream[%0d] got=%b/%h/%b want=1/%h/%b", i - 1, rd_out_valid,
                   {red, green, blue}, transparent, exp_rgb, (k == 4'd0));
        end
      end
    end
    total++;
    if (rd_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_end got=%b want=0", rd_out_valid);
    end
  endtask

  task automatic test_clear();
    int busy_cycles;
    do_write(2'd0, 4'd2, 12'h9C4);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL clear_busy_start got=%b want=1", busy);
    end
    busy_cycles = 0;
    for (int c = 0; c < 200; c++) begin
      if (busy !== 1'b1) break;
      busy_cycles++;
      if (busy_cycles == 10) begin
        // entry {0,2} was already cleared; this write and the restart must both be ignored
        wr_en = 1'b1; wr_pal = 2'd0; wr_index = 4'd2; wr_rgb = 12'hFFF;
        clear_req = 1'b1;
      end else begin
        wr_en = 1'b0;
        clear_req = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0; clear_req = 1'b0;
    total++;
    if (busy_cycles != 64) begin
      bad++;
      $display("FAIL clear_busy_len got=%0d want=64", busy_cycles);
    end
    for (int i = 0; i < 66; i++) begin
      if (i < 64) begin
        rd_valid = 1'b1; {rd_pal, rd_index} = 6'(i);
      end else begin
        rd_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 64) begin
        total++;
        if (rd_out_valid !== 1'b1 || {red, green, blue} !== 12'h000) begin
          bad++;
          $display("FAIL cleared_entry[%0d] got=%b/%h want=1/000", i - 1, rd_out_valid, {red, green, blue});
        end
      end
    end
  endtask

  task automatic test_reset_midclear();
    do_write(2'd3, 4'd4, 12'h555);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    // counter = 0; entry 52 is still intact for a few hundred ns
    rd_valid = 1'b1; rd_pal = 2'd3; rd_index = 4'd4;
    tick();
    rd_valid = 1'b0;
    tick();
    total++;
    if (rd_out_valid !== 1'b1 || {red, green, blue} !== 12'h555 || busy !== 1'b1) begin
      bad++;
      $display("FAIL read_during_clear got=%b/%h/%b want=1/555/1", rd_out_valid, {red, green, blue}, busy);
    end
    repeat (18) tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({rd_out_valid, red, green, blue, transparent, busy} !== 15'd0) begin
      bad++;
      $display("FAIL reset_midclear got=%h want=0", {rd_out_valid, red, green, blue, transparent, busy});
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 66; i++) begin
      if (i < 64) begin
        rd_valid = 1'b1; {rd_pal, rd_index} = 6'(i);
      end else begin
        rd_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 64) begin
        total++;
        if (rd_out_valid !== 1'b1 || {red, green, blue} !== 12'h000) begin
          bad++;
          $display("FAIL reset_entry[%0d] got=%b/%h want=1/000", i - 1, rd_out_valid, {red, green, blue});
        end
      end
    end
  endtask

`ifdef MULTI_PALETTE_FADE_EN
  task automatic test_fade();
    logic [3:0]  lv [3];
    logic [11:0] ex [3];
    lv[0] = 4'd8;  ex[0] = 12'h777;
    lv[1] = 4'd0;  ex[1] = 12'hFFF;
    lv[2] = 4'd15; ex[2] = 12'h000;
    do_write(2'd0, 4'd1, 12'hFFF);
    for (int t = 0; t < 3; t++) begin
      fade_level = lv[t];
      rd_valid = 1'b1; rd_pal = 2'd0; rd_index = 4'd1;
      tick();
      rd_valid = 1'b0;
      tick();
      total++;
      if (rd_out_valid !== 1'b1 || {red, green, blue} !== ex[t]) begin
        bad++;
        $display("FAIL fade_%0d got=%b/%h want=1/%h", lv[t], rd_out_valid, {red, green, blue}, ex[t]);
      end
    end
    fade_level = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_read_first();
    test_transparent_stream();
    test_clear();
    test_reset_midclear();
`ifdef MULTI_PALETTE_FADE_EN
    test_fade();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
